// File: rtl/mips_register_file_if.sv
// Bus bundle between the datapath and the register file: write port,
// two operand read ports, a debug read port and the commit counter.
interface mips_register_file_if #(
    parameter int DATA_W = 32
);
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [31:0]       write_count;

    // Datapath side: drives indices and write data, consumes read data.
    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, dbg_addr,
        input  ReadData1, ReadData2, dbg_data, write_count
    );

    // Register file side.
    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, dbg_addr,
        output ReadData1, ReadData2, dbg_data, write_count
    );
endinterface

// File: rtl/mips_register_file.sv
// 32 x DATA_W MIPS register file. r0 has no storage and always reads zero.
// Reset loads $gp/$sp with their ABI start values and clears everything else.
// Optional write-through bypass on the two operand ports; the debug port
// always shows stored contents.
module mips_register_file #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  SP_INIT = 32'h7FFF_EFFC,
    parameter logic [DATA_W-1:0]  GP_INIT = 32'h1000_8000,
    parameter bit                 BYPASS  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    mips_register_file_if.slave rf
);

    logic [DATA_W-1:0] regs_q [1:31];
    logic [31:0]       write_count_q;
    logic [31:0]       write_count_d;
    logic              wr_commit;

    // A write only lands when enabled, not aimed at r0, and not overridden by reset.
    assign wr_commit     = rf.RegWrite && (rf.WriteReg != 5'd0) && !reset;
    assign write_count_d = write_count_q + {31'd0, wr_commit};

    // Register storage: reset image or a single committed write per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 28)      regs_q[i] <= GP_INIT;
                else if (i == 29) regs_q[i] <= SP_INIT;
                else              regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[rf.WriteReg] <= rf.WriteData;
        end
    end

    // Committed-write counter; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) write_count_q <= '0;
        else       write_count_q <= write_count_d;
    end

    // Operand read ports: r0 forced to zero, optional same-cycle bypass.
    always_comb begin
        rf.ReadData1 = '0;
        rf.ReadData2 = '0;
        if (rf.ReadReg1 != 5'd0) begin
            if (BYPASS && wr_commit && (rf.WriteReg == rf.ReadReg1))
                rf.ReadData1 = rf.WriteData;
            else
                rf.ReadData1 = regs_q[rf.ReadReg1];
        end
        if (rf.ReadReg2 != 5'd0) begin
            if (BYPASS && wr_commit && (rf.WriteReg == rf.ReadReg2))
                rf.ReadData2 = rf.WriteData;
            else
                rf.ReadData2 = regs_q[rf.ReadReg2];
        end
    end

    // Debug port: stored contents only, never bypassed.
    always_comb begin
        rf.dbg_data = '0;
        if (rf.dbg_addr != 5'd0)
            rf.dbg_data = regs_q[rf.dbg_addr];
    end

    assign rf.write_count = write_count_q;

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: one bypassing and one
// non-bypassing instance share the same stimulus; expected values are
// queued by the stimulus and compared by a monitor on the falling edge.
module tb_mips_register_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;

    // sel: 0..3 = bypass DUT rd1/rd2/dbg/count, 4..7 = non-bypass DUT
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [4:0]  dbg_addr = '0;

    always #5 clk = ~clk;

    mips_register_file_if #(.DATA_W(32)) if0 ();
    mips_register_file_if #(.DATA_W(32)) if1 ();

    assign if0.RegWrite  = RegWrite;   assign if1.RegWrite  = RegWrite;
    assign if0.WriteReg  = WriteReg;   assign if1.WriteReg  = WriteReg;
    assign if0.WriteData = WriteData;  assign if1.WriteData = WriteData;
    assign if0.ReadReg1  = ReadReg1;   assign if1.ReadReg1  = ReadReg1;
    assign if0.ReadReg2  = ReadReg2;   assign if1.ReadReg2  = ReadReg2;
    assign if0.dbg_addr  = dbg_addr;   assign if1.dbg_addr  = dbg_addr;

    mips_register_file #(.DATA_W(32), .SP_INIT(SP), .GP_INIT(GP), .BYPASS(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .rf(if0)
    );
    mips_register_file #(.DATA_W(32), .SP_INIT(SP), .GP_INIT(GP), .BYPASS(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .rf(if1)
    );

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0: return if0.ReadData1;
            1: return if0.ReadData2;
            2: return if0.dbg_data;
            3: return if0.write_count;
            4: return if1.ReadData1;
            5: return if1.ReadData2;
            6: return if1.dbg_data;
            default: return if1.write_count;
        endcase
    endfunction

    // Monitor: drain every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.sel);
            n_checks++;
            if (a !== e.exp) begin
                n_errors++;
                $display("FAIL %s: got 32'h%08h expected 32'h%08h", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n; e.sel = sel; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da);
        RegWrite = we; WriteReg = wr; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2; dbg_addr = da;
    endtask

    initial begin
        // Reset for one edge
        step();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        reset = 1'b0;

        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 5'd28);
        expect_v("rst_r0_rd1", 0, 32'd0);
        expect_v("rst_r5_rd2", 1, 32'd0);
        expect_v("rst_gp_dbg", 2, GP);
        expect_v("rst_count", 3, 32'd0);
        expect_v("rst_count_nb", 7, 32'd0);
        step();

        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd28, 5'd29);
        expect_v("rst_sp_rd1", 0, SP);
        expect_v("rst_gp_rd2", 1, GP);
        expect_v("rst_sp_dbg_nb", 6, SP);
        step();

        // Write r8
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd0);
        expect_v("pre_wr8_count", 3, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd8);
        expect_v("r8_rd1", 0, 32'hDEAD_BEEF);
        expect_v("r8_dbg", 2, 32'hDEAD_BEEF);
        expect_v("r8_count", 3, 32'd1);
        expect_v("r8_rd1_nb", 4, 32'hDEAD_BEEF);
        step();

        // Write to r0 is dropped and never bypassed
        drive(1'b1, 5'd0, 32'h1234_5678, 5'd8, 5'd0, 5'd0);
        expect_v("r0_bypass_rd2", 1, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd0);
        expect_v("r0_after_rd2", 1, 32'd0);
        expect_v("r0_dbg", 2, 32'd0);
        expect_v("r0_count", 3, 32'd1);
        step();

        // Same-cycle write r9 with both ports reading r9
        drive(1'b1, 5'd9, 32'hA5A5_0001, 5'd9, 5'd9, 5'd9);
        expect_v("byp_rd1", 0, 32'hA5A5_0001);
        expect_v("byp_rd2", 1, 32'hA5A5_0001);
        expect_v("byp_dbg_old", 2, 32'd0);
        expect_v("nobyp_rd1_old", 4, 32'd0);
        expect_v("nobyp_rd2_old", 5, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
        expect_v("r9_rd1", 0, 32'hA5A5_0001);
        expect_v("r9_dbg", 2, 32'hA5A5_0001);
        expect_v("r9_rd1_nb", 4, 32'hA5A5_0001);
        expect_v("r9_rd2_nb", 5, 32'hA5A5_0001);
        expect_v("r9_count", 3, 32'd2);
        step();

        // Ports evaluated independently: rd1 bypasses r10, rd2 reads r8
        drive(1'b1, 5'd10, 32'h0000_00AA, 5'd10, 5'd8, 5'd10);
        expect_v("ind_rd1", 0, 32'h0000_00AA);
        expect_v("ind_rd2", 1, 32'hDEAD_BEEF);
        expect_v("ind_rd1_nb", 4, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd8, 5'd10);
        expect_v("r10_dbg", 2, 32'h0000_00AA);
        expect_v("r10_count", 3, 32'd3);
        step();

        // Reset dominates a simultaneous write to r29; no bypass under reset
        reset = 1'b1;
        drive(1'b1, 5'd29, 32'h0000_0004, 5'd29, 5'd8, 5'd29);
        expect_v("rstwr_nobyp_rd1", 0, SP);
        step();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd8, 5'd9);
        expect_v("rstwr_sp", 0, SP);
        expect_v("rstwr_r8_clr", 1, 32'd0);
        expect_v("rstwr_r9_clr", 2, 32'd0);
        expect_v("rstwr_count", 3, 32'd0);
        expect_v("rstwr_count_nb", 7, 32'd0);
        step();

        // Back-to-back writes to r5: last writer wins
        drive(1'b1, 5'd5, 32'h0000_0001, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd5, 32'h0000_0002, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
        expect_v("lww_rd1", 0, 32'h0000_0002);
        expect_v("lww_dbg", 2, 32'h0000_0002);
        expect_v("lww_count", 3, 32'd2);
        step();

        // Preload the counter to all-ones through its next-state net
        force u_dut0.write_count_d = 32'hFFFF_FFFF;
        step();
        release u_dut0.write_count_d;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        expect_v("wrap_preload", 3, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 5'd3, 32'h0000_0007, 5'd0, 5'd0, 5'd0);
        expect_v("wrap_pre_edge", 3, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3);
        expect_v("wrap_count", 3, 32'd0);
        expect_v("wrap_r3", 0, 32'h0000_0007);
        step();

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            n_checks++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit general-purpose register file for the monocycle MIPS datapath.
- Sits at the write end of the writeback path. It takes the write-register index from the RegDst selection and the write data from the MemtoReg selection.
- Supplies rs/rt operands to the ALU-source path.
- Provides a debug read port and a committed-write counter for bench visibility.

Parameters:
- DATA_W, 32, register width in bits.
- SP_INIT, 32'h7FFF_EFFC, value loaded into $sp (r29) on reset.
- GP_INIT, 32'h1000_8000, value loaded into $gp (r28) on reset.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports (write-through); 0 = reads return the pre-edge contents.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWrite  in  1  write enable from control.
- WriteReg  in  5  destination register index (rt or rd).
- WriteData  in  DATA_W  writeback value (ALU result or memory data).
- ReadReg1  in  5  rs index.
- ReadReg2  in  5  rt index.
- ReadData1  out  DATA_W  contents of ReadReg1.
- ReadData2  out  DATA_W  contents of ReadReg2.
- dbg_addr  in  5  debug read index.
- dbg_data  out  DATA_W  contents of dbg_addr; never bypassed.
- write_count  out  32  number of committed writes since reset.

Behaviour:
- Storage: 31 physical registers r1..r31. r0 has no storage.
- r0 reads:
  - r0 reads 0 on ReadData1, ReadData2 and dbg_data.
  - Bypass never applies to r0.
- Writes:
  - A write commits on a rising clk edge when RegWrite=1, WriteReg!=0 and reset=0.
  - When WriteReg=0 the write is dropped silently and write_count is not incremented.
- Reads:
  - Read ports are combinational with zero latency.
  - A change on ReadReg1, ReadReg2 or dbg_addr is reflected in the same cycle.
- BYPASS=1:
  - If RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN in the same cycle, ReadDataN=WriteData.
  - The two ports are evaluated independently; both may bypass at once.
  - Bypass is suppressed while reset=1.
- BYPASS=0:
  - ReadDataN shows the old value until the commit edge, and the new value from the following cycle.
- reset=1 at a rising edge:
  - r1..r27, r30 and r31 are set to 0.
  - r28 is set to GP_INIT and r29 is set to SP_INIT.
  - write_count is set to 0.
- Reset priority:
  - Reset dominates a simultaneous write; the write is lost and not counted.
  - Reset in the middle of a program takes effect on that edge with no partial state.
- Before the first reset, register contents are undefined. The bench applies reset before checking any value.
- Output reset values (first cycle after reset):
  - ReadData1, ReadData2 and dbg_data show the post-reset contents of the addressed registers.
  - write_count is 0.
- write_count:
  - Increments by 1 per committed write.
  - Wraps from 32'hFFFF_FFFF to 0 with no flag.
- Repeated writes to the same register are last-writer-wins; one write commits per edge.

Test Plan:
- Apply reset for 1 cycle, then read r0, r5, r28 and r29 -> 0, 0, 32'h1000_8000, 32'h7FFF_EFFC; write_count=0.
- Write r8=32'hDEAD_BEEF with RegWrite=1. Next cycle set ReadReg1=8 and dbg_addr=8 -> both show 32'hDEAD_BEEF; write_count=1.
- Write r0=32'h1234_5678 -> ReadData2 with ReadReg2=0 stays 0; write_count unchanged.
- BYPASS=1: set WriteReg=9, WriteData=32'hA5A5_0001, RegWrite=1, ReadReg1=ReadReg2=9 in the same cycle -> both read ports show 32'hA5A5_0001 before the edge, while dbg_data at addr 9 still shows the old value. Repeat with BYPASS=0 -> read ports show the old value until after the edge.
- Assert reset in the same cycle as a write r29=32'h0000_0004 -> after the edge r29=32'h7FFF_EFFC and write_count=0.
- Preload write_count near wrap via 2^32-1 commits (forced/backdoor preload allowed) -> one more commit gives write_count=0.
